const_builder: RTL and testbench
================================

# const_builder

Sequencer that turns a 64-bit constant request into the minimal LEGv8 MOVZ/MOVK micro-op stream. It drives the zero-extend-and-shift immediate datapath one 16-bit chunk at a time and keeps a shadow accumulator of the value built so far. It sits between decode (constant/literal requests) and the register-write path, and owns all multi-cycle constant materialisation.

## Interface
- No parameters; chunk width is fixed at 16, data width at 64, max 4 micro-ops.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- value  in  64  target constant, sampled with start
- busy  out  1  high while a request is in progress (EMIT)
- uop_valid  out  1  micro-op payload valid
- uop_ready  in  1  consumer accepts payload when uop_valid & uop_ready at a rising edge
- uop_is_movk  out  1  0 = MOVZ, 1 = MOVK
- uop_hw  out  2  chunk index (shift = 16*hw)
- uop_imm  out  16  chunk value, zero-extended to 64 by the datapath
- uop_count  out  3  total micro-ops for the current/last request (1..4)
- acc  out  64  shadow of destination register after each accepted micro-op
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, EMIT, DONE.
- IDLE: on start=1, latch value; compute nz[3:0] (chunk i nonzero); go to EMIT. acc cleared to 0 at the same edge.
- uop_count = popcount(nz), or 1 if value == 0.
- Emission order: ascending chunk index over nonzero chunks only. First micro-op is MOVZ, all following are MOVK.
- value == 0: single MOVZ hw=0 imm=0.
- On each handshake:
  - MOVZ: acc = {48'b0, imm} << 16*hw.
  - MOVK: acc[16*hw +: 16] = imm, other bits kept.
- Advance to the next nonzero chunk after each handshake. After the last handshake go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. acc holds the final value (== latched value) until the next accepted start.
- start is ignored in EMIT and DONE; value is not re-sampled.
- Payload (uop_is_movk, uop_hw, uop_imm) is stable while uop_valid=1 and uop_ready=0. uop_valid never drops before its handshake.
- Reset (any time, including mid-sequence): all outputs 0, state IDLE, latched value and chunk mask cleared. The partial sequence is abandoned with no done pulse.

## Timing
- Reset values: busy=0, uop_valid=0, uop_is_movk=0, uop_hw=0, uop_imm=0, uop_count=0, acc=0, done=0.
- start sampled at edge t: busy=1 and uop_valid=1 with the first payload from cycle t+1.
- With uop_ready held high: one micro-op per cycle. Last handshake at edge t+N (N = uop_count); done=1 and busy=0, uop_valid=0 during cycle t+N+1; IDLE from t+N+2.
- Earliest new start is sampled at edge t+N+2, giving a minimum request period of N+2 cycles.
- acc updates at the handshake edge, so it is visible the cycle after the handshake.
- uop_count is valid from t+1 and holds until the next accepted start.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then start with value=0, ready=1 → one MOVZ hw=0 imm=0x0000; uop_count=1; done pulse at t+2; acc=0.
- value=0x0000_1234_0000_5678, ready=1 → MOVZ hw0 0x5678, then MOVK hw2 0x1234; uop_count=2; acc=0x5678 after the first micro-op and the full value after the second; done at t+3.
- value=0xFFFF_0000_0000_0000 → single MOVZ hw=3 imm=0xFFFF; acc=0xFFFF_0000_0000_0000.
- value=0x1111_2222_3333_4444, ready low for 3 cycles on the 2nd micro-op → payload MOVK hw1 0x3333 held stable throughout; 4 micro-ops total in order hw0,1,2,3; final acc == value.
- start re-pulsed with value=0xDEAD during EMIT → ignored, original sequence completes unchanged. Then reset_n=0 mid-sequence → all outputs 0 immediately, no done pulse; next start behaves as from reset.

Source files
------------

// File: rtl/const_builder_if.sv
// Micro-op stream between the constant builder and the register-write path.
//
// Handshake: the master raises uop_valid with a payload (uop_is_movk, uop_hw,
// uop_imm) and holds valid and payload unchanged until a rising edge where
// uop_valid & uop_ready are both high. That edge transfers the micro-op.
// The slave may drive uop_ready independently of uop_valid.
interface const_builder_if;
  logic        uop_valid;
  logic        uop_ready;
  logic        uop_is_movk;
  logic [1:0]  uop_hw;
  logic [15:0] uop_imm;

  modport master (
    output uop_valid,
    output uop_is_movk,
    output uop_hw,
    output uop_imm,
    input  uop_ready
  );

  modport slave (
    input  uop_valid,
    input  uop_is_movk,
    input  uop_hw,
    input  uop_imm,
    output uop_ready
  );
endinterface

// File: rtl/const_builder.sv
// Turns a 64-bit constant request into the minimal MOVZ/MOVK micro-op stream.
// Only nonzero 16-bit chunks are emitted, lowest first. The first micro-op
// is a MOVZ and the rest are MOVKs. A zero constant becomes a single MOVZ
// hw=0 imm=0. acc mirrors the destination register after each accepted
// micro-op. All outputs are registered.
module const_builder (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [63:0]     value,
  output logic            busy,
  output logic [2:0]      uop_count,
  output logic [63:0]     acc,
  output logic            done,
  output logic [1:0]      dbg_state,
  const_builder_if.master uop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [63:0] value_q;  // constant latched at start
  logic [3:0]  pend_q;   // nonzero chunks not yet presented on the bus

  // One bit per 16-bit chunk, set when that chunk is nonzero.
  function automatic logic [3:0] chunk_mask(input logic [63:0] v);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i] = |v[16*i +: 16];
    end
    return m;
  endfunction

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] idx;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Number of micro-ops for a mask; an all-zero constant still needs one MOVZ.
  function automatic logic [2:0] op_count(input logic [3:0] m);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b0, m[i]};
    end
    if (n == 3'd0) n = 3'd1;
    return n;
  endfunction

  logic [3:0]  start_mask;
  logic [1:0]  start_hw;
  logic [3:0]  start_rest;
  logic [15:0] start_imm;
  logic [1:0]  next_hw;
  logic [3:0]  next_rest;
  logic [15:0] next_imm;
  logic        fire;
  logic [63:0] acc_movz;
  logic [63:0] acc_movk;

  // First chunk of a new request and the following chunk of the current one.
  always_comb begin
    start_mask = chunk_mask(value);
    start_hw   = lowest(start_mask);
    start_rest = start_mask & (start_mask - 4'd1);
    start_imm  = value[{start_hw, 4'b0} +: 16];
    next_hw    = lowest(pend_q);
    next_rest  = pend_q & (pend_q - 4'd1);
    next_imm   = value_q[{next_hw, 4'b0} +: 16];
    fire       = uop.uop_valid & uop.uop_ready;
  end

  // Shadow register update values for the micro-op currently on the bus.
  always_comb begin
    acc_movz = {48'b0, uop.uop_imm} << {uop.uop_hw, 4'b0};
    acc_movk = acc;
    acc_movk[{uop.uop_hw, 4'b0} +: 16] = uop.uop_imm;
  end

  // Sequencer: latch the request, present chunks, step on each handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      value_q         <= 64'd0;
      pend_q          <= 4'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      uop_count       <= 3'd0;
      uop.uop_valid   <= 1'b0;
      uop.uop_is_movk <= 1'b0;
      uop.uop_hw      <= 2'd0;
      uop.uop_imm     <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state           <= ST_EMIT;
            value_q         <= value;
            pend_q          <= start_rest;
            busy            <= 1'b1;
            uop_count       <= op_count(start_mask);
            uop.uop_valid   <= 1'b1;
            uop.uop_is_movk <= 1'b0;
            uop.uop_hw      <= start_hw;
            uop.uop_imm     <= start_imm;
          end
        end
        ST_EMIT: begin
          if (fire) begin
            if (pend_q != 4'd0) begin
              // Payload only changes at a handshake, so it is stable while stalled.
              pend_q          <= next_rest;
              uop.uop_is_movk <= 1'b1;
              uop.uop_hw      <= next_hw;
              uop.uop_imm     <= next_imm;
            end else begin
              state         <= ST_DONE;
              busy          <= 1'b0;
              done          <= 1'b1;
              uop.uop_valid <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          busy          <= 1'b0;
          done          <= 1'b0;
          uop.uop_valid <= 1'b0;
        end
      endcase
    end
  end

  // Shadow accumulator: cleared on an accepted start, updated on each handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= 64'd0;
    end else if (state == ST_IDLE && start) begin
      acc <= 64'd0;
    end else if (state == ST_EMIT && fire) begin
      acc <= uop.uop_is_movk ? acc_movk : acc_movz;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_const_builder.sv
// Directed bench for const_builder. Inputs are driven and outputs sampled at
// the falling edge. Expected values are hand-computed constants.
module tb_const_builder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [63:0] value;
  logic        busy;
  logic [2:0]  uop_count;
  logic [63:0] acc;
  logic        done;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_err;

  const_builder_if bus ();

  const_builder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .uop_count (uop_count),
    .acc       (acc),
    .done      (done),
    .dbg_state (dbg_state),
    .uop       (bus.master)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks one presented micro-op plus busy and the op count.
  task automatic check_uop(input string tag, input logic movk, input logic [1:0] hw,
                           input logic [15:0] imm, input logic [2:0] cnt);
    check({tag, ".valid"}, {63'd0, bus.uop_valid}, 64'd1);
    check({tag, ".busy"},  {63'd0, busy}, 64'd1);
    check({tag, ".movk"},  {63'd0, bus.uop_is_movk}, {63'd0, movk});
    check({tag, ".hw"},    {62'd0, bus.uop_hw}, {62'd0, hw});
    check({tag, ".imm"},   {48'd0, bus.uop_imm}, {48'd0, imm});
    check({tag, ".cnt"},   {61'd0, uop_count}, {61'd0, cnt});
    check({tag, ".done"},  {63'd0, done}, 64'd0);
  endtask

  // Checks the completion cycle.
  task automatic check_done(input string tag, input logic [63:0] exp_acc);
    check({tag, ".done"},  {63'd0, done}, 64'd1);
    check({tag, ".busy"},  {63'd0, busy}, 64'd0);
    check({tag, ".valid"}, {63'd0, bus.uop_valid}, 64'd0);
    check({tag, ".acc"},   acc, exp_acc);
  endtask

  // Checks that every output is at its reset value.
  task automatic check_reset(input string tag);
    check({tag, ".busy"},  {63'd0, busy}, 64'd0);
    check({tag, ".valid"}, {63'd0, bus.uop_valid}, 64'd0);
    check({tag, ".movk"},  {63'd0, bus.uop_is_movk}, 64'd0);
    check({tag, ".hw"},    {62'd0, bus.uop_hw}, 64'd0);
    check({tag, ".imm"},   {48'd0, bus.uop_imm}, 64'd0);
    check({tag, ".cnt"},   {61'd0, uop_count}, 64'd0);
    check({tag, ".acc"},   acc, 64'd0);
    check({tag, ".done"},  {63'd0, done}, 64'd0);
  endtask

  // Driver: pulse start for one rising edge; returns at the falling edge after it.
  task automatic drive_start(input logic [63:0] v);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    value = 64'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    start = 1'b0;
    value = 64'd0;
    bus.uop_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Zero constant: single MOVZ hw0 imm0
    bus.uop_ready = 1'b1;
    drive_start(64'd0);
    check_uop("z.u0", 1'b0, 2'd0, 16'h0000, 3'd1);
    @(negedge clk);
    check_done("z.end", 64'd0);
    @(negedge clk);
    check("z.done_off", {63'd0, done}, 64'd0);

    // Two nonzero chunks: hw0 then hw2
    drive_start(64'h0000_1234_0000_5678);
    check_uop("a.u0", 1'b0, 2'd0, 16'h5678, 3'd2);
    check("a.acc0", acc, 64'd0);
    @(negedge clk);
    check_uop("a.u1", 1'b1, 2'd2, 16'h1234, 3'd2);
    check("a.acc1", acc, 64'h0000_0000_0000_5678);
    @(negedge clk);
    check_done("a.end", 64'h0000_1234_0000_5678);
    @(negedge clk);
    check("a.hold_acc", acc, 64'h0000_1234_0000_5678);
    check("a.hold_cnt", {61'd0, uop_count}, 64'd2);

    // Top chunk only: single MOVZ hw3
    drive_start(64'hFFFF_0000_0000_0000);
    check_uop("b.u0", 1'b0, 2'd3, 16'hFFFF, 3'd1);
    @(negedge clk);
    check_done("b.end", 64'hFFFF_0000_0000_0000);
    @(negedge clk);

    // Four chunks, stall on the second micro-op, ignored start during EMIT
    drive_start(64'h1111_2222_3333_4444);
    check_uop("c.u0", 1'b0, 2'd0, 16'h4444, 3'd4);
    @(negedge clk);
    bus.uop_ready = 1'b0;
    check_uop("c.u1", 1'b1, 2'd1, 16'h3333, 3'd4);
    check("c.acc1", acc, 64'h0000_0000_0000_4444);
    start = 1'b1;
    value = 64'h0000_0000_0000_DEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      value = 64'd0;
      check_uop("c.stall", 1'b1, 2'd1, 16'h3333, 3'd4);
      check("c.stall_acc", acc, 64'h0000_0000_0000_4444);
    end
    bus.uop_ready = 1'b1;
    @(negedge clk);
    check_uop("c.u2", 1'b1, 2'd2, 16'h2222, 3'd4);
    check("c.acc2", acc, 64'h0000_0000_3333_4444);
    @(negedge clk);
    check_uop("c.u3", 1'b1, 2'd3, 16'h1111, 3'd4);
    check("c.acc3", acc, 64'h0000_2222_3333_4444);
    @(negedge clk);
    check_done("c.end", 64'h1111_2222_3333_4444);
    @(negedge clk);
    check("c.idle_state", {62'd0, dbg_state}, 64'd0);

    // Reset in the middle of a sequence
    drive_start(64'h0001_0002_0003_0004);
    check_uop("d.u0", 1'b0, 2'd0, 16'h0004, 3'd4);
    @(negedge clk);
    check_uop("d.u1", 1'b1, 2'd1, 16'h0003, 3'd4);
    reset_n = 1'b0;
    #1;
    check_reset("d.rst");
    @(negedge clk);
    check_reset("d.rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    check("d.no_done", {63'd0, done}, 64'd0);

    // Fresh request after the abandoned sequence
    drive_start(64'h0000_ABCD_0000_0000);
    check_uop("e.u0", 1'b0, 2'd2, 16'hABCD, 3'd1);
    check("e.acc0", acc, 64'd0);
    @(negedge clk);
    check_done("e.end", 64'h0000_ABCD_0000_0000);
    @(negedge clk);
    check("e.done_off", {63'd0, done}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
